// File: rtl/my_dmux_16_reg_if.sv
// Bus bundle for the registered 1-to-2 demultiplexer: one valid/ready input
// stream, two valid/ready output channels and their transfer counters.
interface my_dmux_16_reg_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_out;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] b_out;
   logic             b_valid;
   logic             b_ready;
   logic [CNT_W-1:0] a_count;
   logic [CNT_W-1:0] b_count;

   // Producer and consumers side of the bundle.
   modport master (
      output in_data, in_sel, in_valid, a_ready, b_ready,
      input  in_ready, a_out, a_valid, b_out, b_valid, a_count, b_count
   );

   // Demultiplexer side of the bundle.
   modport slave (
      input  in_data, in_sel, in_valid, a_ready, b_ready,
      output in_ready, a_out, a_valid, b_out, b_valid, a_count, b_count
   );
endinterface

// File: rtl/my_dmux_16_reg.sv
// Registered 1-to-2 demultiplexer. Each accepted word is steered by in_sel
// into a one-entry output register for channel A (sel=0) or B (sel=1).
// A channel can drain and reload in the same cycle, so a consumer holding
// ready high sees one word per cycle. Completed transfers are counted per
// channel with wrap-around counters.
module my_dmux_16_reg #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   my_dmux_16_reg_if.slave  bus
);

   logic [WIDTH-1:0] a_out_q, a_out_d;
   logic [WIDTH-1:0] b_out_q, b_out_d;
   logic             a_valid_q, a_valid_d;
   logic             b_valid_q, b_valid_d;
   logic [CNT_W-1:0] a_count_q, a_count_d;
   logic [CNT_W-1:0] b_count_q, b_count_d;

   logic a_drain, b_drain;
   logic a_load, b_load;
   logic in_ready;

   // Handshake decode: ready looks only at the selected channel, never at in_valid.
   always_comb begin
      a_drain  = a_valid_q & bus.a_ready;
      b_drain  = b_valid_q & bus.b_ready;
      in_ready = bus.in_sel ? (!b_valid_q | bus.b_ready)
                            : (!a_valid_q | bus.a_ready);
      a_load   = bus.in_valid & in_ready & !bus.in_sel;
      b_load   = bus.in_valid & in_ready &  bus.in_sel;
   end

   // Next-state for both channel registers and counters.
   always_comb begin
      // NOTE: every target gets its hold value first, so no path leaves a
      // signal unassigned and no latch is inferred.
      a_out_d   = a_out_q;
      b_out_d   = b_out_q;
      a_valid_d = a_valid_q;
      b_valid_d = b_valid_q;
      a_count_d = a_count_q;
      b_count_d = b_count_q;

      if (a_drain) begin
         a_valid_d = 1'b0;
         a_count_d = a_count_q + CNT_W'(1);
      end
      // A load after the drain wins, keeping valid high on a same-cycle swap.
      if (a_load) begin
         a_valid_d = 1'b1;
         a_out_d   = bus.in_data;
      end

      if (b_drain) begin
         b_valid_d = 1'b0;
         b_count_d = b_count_q + CNT_W'(1);
      end
      if (b_load) begin
         b_valid_d = 1'b1;
         b_out_d   = bus.in_data;
      end
   end

   // State registers; a reset discards any held word and clears the counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data registers are reset too, because the outputs must
         // read zero during reset, not just be flagged invalid.
         a_out_q   <= '0;
         b_out_q   <= '0;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         a_count_q <= '0;
         b_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         a_out_q   <= a_out_d;
         b_out_q   <= b_out_d;
         a_valid_q <= a_valid_d;
         b_valid_q <= b_valid_d;
         a_count_q <= a_count_d;
         b_count_q <= b_count_d;
      end
   end

   // Drive the bundle outputs from the registers.
   always_comb begin
      bus.in_ready = in_ready;
      bus.a_out    = a_out_q;
      bus.a_valid  = a_valid_q;
      bus.b_out    = b_out_q;
      bus.b_valid  = b_valid_q;
      bus.a_count  = a_count_q;
      bus.b_count  = b_count_q;
   end

endmodule
